// File: rtl/mdio_master_param.sv
// mdio_master_param: MDIO management master for Clause 22 and Clause 45 frames.
// A 32-bit frame word is latched on request and shifted out MSB first on MDIO.
// An optional all-ones preamble comes first. For reads the pad is released for
// the turnaround and data bits, and 16 bits are assembled from MDIO_IN.
module mdio_master_param #(
  parameter int CLK_DIV = 2,   // clk cycles per MDC half-period (>= 1)
  parameter int PRE_LEN = 32   // preamble bits, 0..63
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  // Whole transaction in MDC bits: preamble, then the 32-bit frame.
  localparam int TOTAL      = PRE_LEN + 32;
  localparam int BIT_W      = $clog2(TOTAL);
  localparam int CNT_W      = $clog2(2 * CLK_DIV);
  // Frame bit 17 (the first TA bit) sits 14 bits after the preamble.
  localparam int TAIL_START = PRE_LEN + 14;
  // Frame bit 15 (the first data bit) sits 16 bits after the preamble.
  localparam int READ_START = PRE_LEN + 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ADDR,
    ST_TAIL,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic [CNT_W-1:0]  cnt;        // position within the current bit period
  logic [BIT_W-1:0]  bit_idx;    // bit number within the whole transaction
  logic [31:0]       sreg;       // frame shift register, MSB is the bit on the wire
  logic [31:0]       nxt_sreg;
  logic              is_read;
  logic [15:0]       rd_shift;

  logic              mdc_r;
  logic              out_r;
  logic              oe_r;
  logic [15:0]       rd_r;
  logic              rdy_r;
  logic              busy_r;

  logic              bit_end;
  logic              mdc_rise;
  logic              last_bit;
  int                nb;

  // Decode where the bit counter is and what the next bit will be.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    bit_end   = (cnt == CNT_W'(2 * CLK_DIV - 1));
    mdc_rise  = (cnt == CNT_W'(CLK_DIV - 1));
    last_bit  = (int'(bit_idx) == TOTAL - 1);
    nb        = int'(bit_idx) + 1;
    // The preamble does not consume frame bits. Frame bits shift out one per bit.
    nxt_sreg  = (state == ST_PRE) ? sreg : {sreg[30:0], 1'b0};
    if (nb < PRE_LEN)         nxt_state = ST_PRE;
    else if (nb < TAIL_START) nxt_state = ST_ADDR;
    else                      nxt_state = ST_TAIL;
  end

  // FSM, MDC divider, shift registers and all registered pad/status outputs.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sreg     <= '0;
      is_read  <= 1'b0;
      rd_shift <= '0;
      mdc_r    <= 1'b0;
      out_r    <= 1'b1;
      oe_r     <= 1'b0;
      rd_r     <= '0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rdy_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          mdc_r  <= 1'b0;
          out_r  <= 1'b1;
          oe_r   <= 1'b0;
          busy_r <= 1'b0;
          if (MDIO_START) begin
            sreg    <= T_DATA;
            is_read <= T_DATA[29];
            cnt     <= '0;
            bit_idx <= '0;
            busy_r  <= 1'b1;
            oe_r    <= 1'b1;
            if (PRE_LEN == 0) begin
              state <= ST_ADDR;
              out_r <= T_DATA[31];
            end else begin
              state <= ST_PRE;
              out_r <= 1'b1;
            end
          end
        end

        ST_PRE, ST_ADDR, ST_TAIL: begin
          if (bit_end) begin
            // Bit boundary: MDC falls, and the pad changes only here.
            cnt   <= '0;
            mdc_r <= 1'b0;
            if (last_bit) begin
              state <= ST_DONE;
              oe_r  <= 1'b0;
              out_r <= 1'b1;
              rdy_r <= 1'b1;
              if (is_read) rd_r <= rd_shift;
            end else begin
              state   <= nxt_state;
              bit_idx <= bit_idx + 1'b1;
              sreg    <= nxt_sreg;
              if (nxt_state == ST_PRE) begin
                out_r <= 1'b1;
                oe_r  <= 1'b1;
              end else if (nxt_state == ST_TAIL && is_read) begin
                // The PHY owns the line for the turnaround and the data.
                out_r <= 1'b1;
                oe_r  <= 1'b0;
              end else begin
                out_r <= nxt_sreg[31];
                oe_r  <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (mdc_rise) begin
              // MDC rises here; the read data is captured on the same edge.
              mdc_r <= 1'b1;
              if (state == ST_TAIL && is_read && int'(bit_idx) >= READ_START)
                rd_shift <= {rd_shift[14:0], MDIO_IN};
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          mdc_r  <= 1'b0;
          out_r  <= 1'b1;
          oe_r   <= 1'b0;
        end

        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          mdc_r  <= 1'b0;
          out_r  <= 1'b1;
          oe_r   <= 1'b0;
        end
      endcase
    end
  end

  assign MDC      = mdc_r;
  assign MDIO_OUT = out_r;
  assign MDIO_OE  = oe_r;
  assign RD_DATA  = rd_r;
  assign DATA_RDY = rdy_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_mdio_master_param.sv
// tb_mdio_master_param: bench for two instances of the MDIO master. Unit 0 uses
// the default parameters. Unit 1 uses CLK_DIV=1 and PRE_LEN=0. Each transaction
// is observed cycle by cycle. The result is compared with the expected wire
// image and timing, which the bench computes from the frame rules.
module tb_mdio_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           start_v;
  logic [1:0][31:0]     tdata_v;
  logic [1:0]           min_v;
  wire  [1:0]           mdc_v;
  wire  [1:0]           out_v;
  wire  [1:0]           oe_v;
  wire  [1:0]           rdy_v;
  wire  [1:0]           busy_v;
  wire  [1:0][15:0]     rd_v;

  int          n_checks;
  int          n_pass;
  logic [15:0] exp_rd [2];

  mdio_master_param u0 (
    .clk(clk), .RESET(rst_n), .MDIO_START(start_v[0]), .T_DATA(tdata_v[0]),
    .MDIO_IN(min_v[0]), .MDC(mdc_v[0]), .MDIO_OUT(out_v[0]), .MDIO_OE(oe_v[0]),
    .RD_DATA(rd_v[0]), .DATA_RDY(rdy_v[0]), .BUSY(busy_v[0])
  );

  mdio_master_param #(.CLK_DIV(1), .PRE_LEN(0)) u1 (
    .clk(clk), .RESET(rst_n), .MDIO_START(start_v[1]), .T_DATA(tdata_v[1]),
    .MDIO_IN(min_v[1]), .MDC(mdc_v[1]), .MDIO_OUT(out_v[1]), .MDIO_OE(oe_v[1]),
    .RD_DATA(rd_v[1]), .DATA_RDY(rdy_v[1]), .BUSY(busy_v[1])
  );

  function automatic int cd_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int pl_of(input int u);
    return (u == 0) ? 32 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transaction on unit u. The bench acts as the PHY: it returns phy on
  // frame positions 15..0 and noise elsewhere. abort_bit >= 0 pulls reset
  // during that transaction bit.
  task automatic run_txn(input int u, input logic [31:0] word, input logic [15:0] phy,
                         input bit inject, input int abort_bit);
    int pl, cd, per, nbits, tlast, abort_k, f;
    int rises, shape_err, stab_err, busy_err, rdy_cnt, rdy_cyc, done_err;
    bit rd_op, aborted;
    logic [63:0] pre_vec;
    logic [31:0] out_vec, oe_vec, exp_out, exp_oe;
    logic [15:0] rd_at, exp_rdv;
    logic prev_mdc, prev_out, prev_oe;

    pl = pl_of(u); cd = cd_of(u); per = 2 * cd; nbits = pl + 32;
    tlast = nbits * per + 1;
    rd_op = word[29];
    abort_k = (abort_bit >= 0) ? (pl + abort_bit) * per + 2 : -1;
    rises = 0; shape_err = 0; stab_err = 0; busy_err = 0;
    rdy_cnt = 0; rdy_cyc = -1; done_err = 0; aborted = 0;
    pre_vec = '0; out_vec = '0; oe_vec = '0; rd_at = '0;
    prev_mdc = 1'b0; prev_out = 1'b1; prev_oe = 1'b0;

    start_v[u] = 1'b1;
    tdata_v[u] = word;
    @(posedge clk);   // accept edge
    for (int k = 1; k <= tlast + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin start_v[u] = 1'b0; tdata_v[u] = $urandom; end
      if (inject && (k == 40 || k == tlast)) begin start_v[u] = 1'b1; tdata_v[u] = ~word; end
      if (inject && (k == 41 || k == tlast + 1)) start_v[u] = 1'b0;

      // PHY model
      f = (k - 1) / per - pl;
      if (k <= nbits * per && f >= 16 && f <= 31) min_v[u] = phy[31 - f];
      else min_v[u] = 1'($urandom);

      if (aborted && k == abort_k + 1) begin
        check("abort_reset", {mdc_v[u], out_v[u], oe_v[u], rdy_v[u], busy_v[u], rd_v[u]},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
      end

      if (!aborted) begin
        if (k <= nbits * per) begin
          if (mdc_v[u] !== 1'(((k - 1) % per) >= cd)) shape_err++;
          if (((k - 1) % per) != 0 && (out_v[u] !== prev_out || oe_v[u] !== prev_oe)) stab_err++;
          if (mdc_v[u] === 1'b1 && prev_mdc === 1'b0) begin
            if (rises < pl) pre_vec[rises] = out_v[u] & oe_v[u];
            else if (rises < nbits) begin
              out_vec[31 - (rises - pl)] = out_v[u];
              oe_vec[31 - (rises - pl)]  = oe_v[u];
            end
            rises++;
          end
        end else if (mdc_v[u] !== 1'b0) shape_err++;
        if (busy_v[u] !== 1'(k <= tlast)) busy_err++;
      end

      if (rdy_v[u] === 1'b1) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = k;
          rd_at = rd_v[u];
          if (mdc_v[u] !== 1'b0 || oe_v[u] !== 1'b0) done_err++;
        end
      end
      prev_mdc = mdc_v[u]; prev_out = out_v[u]; prev_oe = oe_v[u];

      if (k == abort_k) begin rst_n = 1'b0; aborted = 1; end
    end

    if (aborted) begin
      check("abort_no_rdy", 64'(rdy_cnt), 64'd0);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      exp_out = rd_op ? {word[31:18], 18'h3FFFF} : word;
      exp_oe  = rd_op ? {14'h3FFF, 18'h00000} : 32'hFFFF_FFFF;
      exp_rdv = rd_op ? phy : exp_rd[u];
      check("mdc_rises",   64'(rises),     64'(nbits));
      check("preamble",    pre_vec,        (64'd1 << pl) - 64'd1);
      check("frame_out",   64'(out_vec),   64'(exp_out));
      check("frame_oe",    64'(oe_vec),    64'(exp_oe));
      check("mdc_shape",   64'(shape_err), 64'd0);
      check("pad_stable",  64'(stab_err),  64'd0);
      check("busy",        64'(busy_err),  64'd0);
      check("rdy_count",   64'(rdy_cnt),   64'd1);
      check("rdy_cycle",   64'(rdy_cyc),   64'(tlast));
      check("done_pad",    64'(done_err),  64'd0);
      check("rd_data",     64'(rd_at),     64'(exp_rdv));
      exp_rd[u] = exp_rdv;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    start_v = 2'b11;
    tdata_v[0] = $urandom;
    tdata_v[1] = $urandom;
    min_v = 2'b00;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset held with a pending request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      check("reset_state", {mdc_v[u], out_v[u], oe_v[u], rdy_v[u], busy_v[u], rd_v[u]},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    start_v = 2'b00;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_start", {busy_v, rdy_v}, 4'b0000);

    // Directed frames
    run_txn(0, 32'h5082_1234, 16'h0000, 0, -1);               // C22 write
    run_txn(0, 32'h6082_0000, 16'hBEEF, 0, -1);               // C22 read
    run_txn(1, 32'h2000_0000, 16'h0001, 0, -1);               // C45 post-read-increment
    run_txn(0, $urandom & 32'hDFFF_FFFF, 16'h0000, 1, -1);    // busy rejection
    run_txn(0, $urandom | 32'h2000_0000, 16'($urandom), 0, 20); // reset mid-frame
    repeat (2) @(negedge clk);
    run_txn(0, $urandom & 32'hDFFF_FFFF, 16'h0000, 0, -1);    // fresh write after abort

    // Randomized frames on both units
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(i % 2, $urandom, 16'($urandom), (i % 2 == 0) && ($urandom_range(0, 1) == 1), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
